morra_driver: RTL and testbench

MORRA_DRIVER -- requirements
Module: morra_driver

---
 rtl/morra_driver.sv | 157 +++++++++++++++
 tb/tb_morra_driver.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/morra_driver.sv
// Morra match driver: plays one match of LFSR-generated moves against an external referee.
// Define MORRA_DRV_CHECK_EN to build the checker that flags referee round results it disagrees with.
module morra_driver (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] cfg_rounds,
    input  logic [1:0] manche,
    input  logic [1:0] partita,
    output logic [1:0] i1,
    output logic [1:0] i2,
    output logic       inizio,
    output logic       busy,
    output logic       done,
    output logic [1:0] result,
    output logic [4:0] wins1,
    output logic [4:0] wins2,
    output logic [4:0] rounds,
    output logic       mismatch,
    output logic [2:0] dbg_state
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        INIT = 3'd1,
        PLAY = 3'd2,
        WAIT = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam logic [15:0] LFSR_SEED   = 16'hACE1;
    localparam logic [4:0]  ROUND_LIMIT = 5'd20;

    state_t      state, state_next;
    logic        init_cnt;
    logic [3:0]  cfg_q;
    logic [15:0] lfsr;
    logic [1:0]  mv1, mv2;
    logic [1:0]  i1_d, i2_d;
    logic        inizio_d;
    logic        round_valid;
    logic [4:0]  rounds_nx;

    function automatic logic [4:0] sat_inc(input logic [4:0] v);
        return (v == 5'd31) ? v : v + 5'd1;
    endfunction

    // The move code 00 is not a legal move, so it is folded onto rock.
    assign mv1         = (lfsr[1:0] == 2'b00) ? 2'b01 : lfsr[1:0];
    assign mv2         = (lfsr[9:8] == 2'b00) ? 2'b01 : lfsr[9:8];
    assign round_valid = (manche != 2'b00);
    assign rounds_nx   = round_valid ? sat_inc(rounds) : rounds;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = INIT;
            INIT: if (init_cnt) state_next = PLAY;
            PLAY: state_next = WAIT;
            WAIT: begin
                if (partita != 2'b00 || rounds_nx >= ROUND_LIMIT) state_next = DONE;
                else                                              state_next = PLAY;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs are computed from the upcoming state so they line up with it.
    always_comb begin
        i1_d      = 2'b00;
        i2_d      = 2'b00;
        inizio_d  = 1'b0;
        busy      = (state != IDLE);
        done      = (state == DONE);
        dbg_state = state;
        case (state_next)
            INIT: begin
                inizio_d     = 1'b1;
                {i1_d, i2_d} = (state == IDLE) ? cfg_rounds : cfg_q;
            end
            PLAY: begin
                i1_d = mv1;
                i2_d = mv2;
            end
            WAIT: begin
                i1_d = i1;
                i2_d = i2;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            init_cnt <= 1'b0;
            cfg_q    <= 4'd0;
            lfsr     <= LFSR_SEED;
            i1       <= 2'b00;
            i2       <= 2'b00;
            inizio   <= 1'b0;
            result   <= 2'b00;
            wins1    <= 5'd0;
            wins2    <= 5'd0;
            rounds   <= 5'd0;
        end else begin
            i1       <= i1_d;
            i2       <= i2_d;
            inizio   <= inizio_d;
            init_cnt <= (state == INIT) && !init_cnt;
            if (state == PLAY)
                lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
            if (state == IDLE && start) begin
                cfg_q  <= cfg_rounds;
                result <= 2'b00;
                wins1  <= 5'd0;
                wins2  <= 5'd0;
                rounds <= 5'd0;
            end
            if (state == WAIT) begin
                rounds <= rounds_nx;
                if (manche == 2'b01) wins1 <= sat_inc(wins1);
                if (manche == 2'b10) wins2 <= sat_inc(wins2);
                if (partita != 2'b00) result <= partita;
            end
        end
    end

`ifdef MORRA_DRV_CHECK_EN
    logic [1:0] manche_exp;

    // Moves are held through WAIT, so the round outcome is judged from i1/i2 directly.
    always_comb begin
        if (i1 == i2)
            manche_exp = 2'b11;
        else if ((i1 == 2'b01 && i2 == 2'b11) || (i1 == 2'b10 && i2 == 2'b01) ||
                 (i1 == 2'b11 && i2 == 2'b10))
            manche_exp = 2'b01;
        else
            manche_exp = 2'b10;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            mismatch <= 1'b0;
        else if (state == WAIT && manche != manche_exp)
            mismatch <= 1'b1;
    end
`else
    assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_morra_driver.sv
// Directed bench for morra_driver: a referee model drives round/match results at each WAIT.
module tb_morra_driver;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_INIT = 3'd1;
    localparam logic [2:0] S_PLAY = 3'd2;
    localparam logic [2:0] S_WAIT = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] cfg_rounds = 4'd0;
    logic [1:0] manche = 2'b00;
    logic [1:0] partita = 2'b00;
    logic [1:0] i1, i2, result;
    logic       inizio, busy, done, mismatch;
    logic [4:0] wins1, wins2, rounds;
    logic [2:0] dbg_state;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] m_lfsr = 16'hACE1;

    always #5 clk = ~clk;

    morra_driver dut (
        .clk(clk), .rst_n(rst_n), .start(start), .cfg_rounds(cfg_rounds),
        .manche(manche), .partita(partita), .i1(i1), .i2(i2), .inizio(inizio),
        .busy(busy), .done(done), .result(result), .wins1(wins1), .wins2(wins2),
        .rounds(rounds), .mismatch(mismatch), .dbg_state(dbg_state)
    );

    function automatic logic [1:0] map_move(input logic [1:0] c);
        return (c == 2'b00) ? 2'b01 : c;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[15:1]};
    endfunction

    function automatic logic [1:0] model_manche(input logic [15:0] l);
        logic [1:0] a, b;
        a = map_move(l[1:0]);
        b = map_move(l[9:8]);
        if (a == b) return 2'b11;
        if ((a == 2'b01 && b == 2'b11) || (a == 2'b10 && b == 2'b01) || (a == 2'b11 && b == 2'b10))
            return 2'b01;
        return 2'b10;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        manche = 2'b00;
        partita = 2'b00;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_lfsr = 16'hACE1;
    endtask

    // Leaves the bench at the negedge inside the first PLAY cycle.
    task automatic start_match(input logic [3:0] cfg);
        cfg_rounds = cfg;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
    endtask

    // Called in a PLAY cycle; answers the following WAIT with the given results.
    task automatic play_round(input logic [1:0] m, input logic [1:0] p);
        logic [1:0] e1, e2;
        e1 = map_move(m_lfsr[1:0]);
        e2 = map_move(m_lfsr[9:8]);
        n_vec++;
        if ({dbg_state, inizio, busy, i1, i2} !== {S_PLAY, 1'b0, 1'b1, e1, e2}) begin
            n_err++;
            $display("FAIL play_moves: state/inizio/busy/i1/i2 got %h %b %b %b %b expected %h 0 1 %b %b",
                     dbg_state, inizio, busy, i1, i2, S_PLAY, e1, e2);
        end
        m_lfsr = lfsr_step(m_lfsr);
        @(negedge clk);
        manche = m;
        partita = p;
        @(negedge clk);
        manche = 2'b00;
        partita = 2'b00;
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++;
        if ({dbg_state, i1, i2, inizio, busy, done, result, wins1, wins2, rounds, mismatch} !==
            {S_IDLE, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_state: got state=%h i1=%b i2=%b inizio=%b busy=%b done=%b result=%b w1=%0d w2=%0d r=%0d mm=%b, expected all zero",
                     dbg_state, i1, i2, inizio, busy, done, result, wins1, wins2, rounds, mismatch);
        end
    endtask

    task automatic test_init();
        cfg_rounds = 4'b0010;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 0; c < 2; c++) begin
            n_vec++;
            if ({dbg_state, inizio, i1, i2, busy, done} !== {S_INIT, 1'b1, 2'b00, 2'b10, 1'b1, 1'b0}) begin
                n_err++;
                $display("FAIL init_cycle%0d: state=%h inizio=%b i1=%b i2=%b busy=%b done=%b expected 1 1 00 10 1 0",
                         c, dbg_state, inizio, i1, i2, busy, done);
            end
            @(negedge clk);
        end
        // Seed ACE1: bits[1:0]=01 -> rock, bits[9:8]=00 -> rock.
        n_vec++;
        if ({dbg_state, inizio, i1, i2} !== {S_PLAY, 1'b0, 2'b01, 2'b01}) begin
            n_err++;
            $display("FAIL first_play: state=%h inizio=%b i1=%b i2=%b expected 2 0 01 01", dbg_state, inizio, i1, i2);
        end
    endtask

    task automatic test_match();
        play_round(2'b01, 2'b00);
        play_round(2'b10, 2'b00);
        play_round(2'b11, 2'b00);
        play_round(2'b01, 2'b01);
        n_vec++;
        if ({dbg_state, done, busy, i1, i2, wins1, wins2, rounds, result} !==
            {S_DONE, 1'b1, 1'b1, 2'b00, 2'b00, 5'd2, 5'd1, 5'd4, 2'b01}) begin
            n_err++;
            $display("FAIL match_done: state=%h done=%b busy=%b i1=%b i2=%b w1=%0d w2=%0d r=%0d res=%b expected 4 1 1 00 00 2 1 4 01",
                     dbg_state, done, busy, i1, i2, wins1, wins2, rounds, result);
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        n_vec++;
        if ({dbg_state, done, busy, wins1, wins2, rounds, result} !==
            {S_IDLE, 1'b0, 1'b0, 5'd2, 5'd1, 5'd4, 2'b01}) begin
            n_err++;
            $display("FAIL match_hold: state=%h done=%b busy=%b w1=%0d w2=%0d r=%0d res=%b expected 0 0 0 2 1 4 01",
                     dbg_state, done, busy, wins1, wins2, rounds, result);
        end
        @(negedge clk);
        n_vec++;
        if ({dbg_state, busy} !== {S_IDLE, 1'b0}) begin
            n_err++;
            $display("FAIL start_in_done: state=%h busy=%b expected 0 0", dbg_state, busy);
        end
    endtask

    task automatic test_void_rounds();
        start_match(4'hF);
        play_round(2'b00, 2'b00);
        n_vec++;
        if ({dbg_state, wins1, wins2, rounds, result} !== {S_PLAY, 5'd0, 5'd0, 5'd0, 2'b00}) begin
            n_err++;
            $display("FAIL void_round: state=%h w1=%0d w2=%0d r=%0d res=%b expected 2 0 0 0 00",
                     dbg_state, wins1, wins2, rounds, result);
        end
        play_round(2'b00, 2'b00);
        play_round(2'b10, 2'b10);
        n_vec++;
        if ({dbg_state, wins1, wins2, rounds, result} !== {S_DONE, 5'd0, 5'd1, 5'd1, 2'b10}) begin
            n_err++;
            $display("FAIL void_done: state=%h w1=%0d w2=%0d r=%0d res=%b expected 4 0 1 1 10",
                     dbg_state, wins1, wins2, rounds, result);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        start_match(4'h0);
        for (int r = 0; r < 19; r++) play_round(2'b11, 2'b00);
        n_vec++;
        if ({dbg_state, rounds} !== {S_PLAY, 5'd19}) begin
            n_err++;
            $display("FAIL timeout_19: state=%h rounds=%0d expected 2 19", dbg_state, rounds);
        end
        play_round(2'b11, 2'b00);
        n_vec++;
        if ({dbg_state, done, rounds, wins1, wins2, result} !== {S_DONE, 1'b1, 5'd20, 5'd0, 5'd0, 2'b00}) begin
            n_err++;
            $display("FAIL timeout_done: state=%h done=%b r=%0d w1=%0d w2=%0d res=%b expected 4 1 20 0 0 00",
                     dbg_state, done, rounds, wins1, wins2, result);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid_match();
        cfg_rounds = 4'h5;
        start = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        if (dbg_state !== S_INIT) begin
            n_err++;
            $display("FAIL restart_in_init: state=%h expected 1", dbg_state);
        end
        @(negedge clk);
        n_vec++;
        if (dbg_state !== S_PLAY) begin
            n_err++;
            $display("FAIL start_busy_play: state=%h expected 2", dbg_state);
        end
        @(negedge clk);
        start = 1'b0;
        n_vec++;
        if (dbg_state !== S_WAIT) begin
            n_err++;
            $display("FAIL start_busy_wait: state=%h expected 3", dbg_state);
        end
        rst_n = 1'b0;
        manche = 2'b01;
        partita = 2'b01;
        @(negedge clk);
        manche = 2'b00;
        partita = 2'b00;
        n_vec++;
        if ({dbg_state, i1, i2, inizio, busy, done, result, wins1, wins2, rounds, mismatch} !==
            {S_IDLE, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 5'd0, 5'd0, 5'd0, 1'b0}) begin
            n_err++;
            $display("FAIL abort_reset: state=%h i1=%b i2=%b inizio=%b busy=%b done=%b res=%b w1=%0d w2=%0d r=%0d mm=%b expected all zero",
                     dbg_state, i1, i2, inizio, busy, done, result, wins1, wins2, rounds, mismatch);
        end
        rst_n = 1'b1;
        m_lfsr = 16'hACE1;
        start_match(4'h0);
        n_vec++;
        if ({dbg_state, i1, i2} !== {S_PLAY, 2'b01, 2'b01}) begin
            n_err++;
            $display("FAIL lfsr_reseed: state=%h i1=%b i2=%b expected 2 01 01", dbg_state, i1, i2);
        end
        play_round(2'b11, 2'b11);
        @(negedge clk);
    endtask

    task automatic test_checker();
        logic [1:0] good, bad;
        do_reset();
        start_match(4'h3);
        play_round(model_manche(m_lfsr), 2'b00);
        play_round(model_manche(m_lfsr), 2'b00);
        n_vec++;
        if (mismatch !== 1'b0) begin
            n_err++;
            $display("FAIL check_clean: mismatch=%b expected 0", mismatch);
        end
        good = model_manche(m_lfsr);
        bad = (good == 2'b01) ? 2'b10 : 2'b01;
        play_round(bad, 2'b00);
`ifdef MORRA_DRV_CHECK_EN
        n_vec++;
        if (mismatch !== 1'b1) begin
            n_err++;
            $display("FAIL check_flag: mismatch=%b expected 1", mismatch);
        end
        play_round(model_manche(m_lfsr), 2'b01);
        @(negedge clk);
        n_vec++;
        if ({dbg_state, mismatch} !== {S_IDLE, 1'b1}) begin
            n_err++;
            $display("FAIL check_sticky: state=%h mismatch=%b expected 0 1", dbg_state, mismatch);
        end
`else
        n_vec++;
        if (mismatch !== 1'b0) begin
            n_err++;
            $display("FAIL check_off: mismatch=%b expected 0", mismatch);
        end
        play_round(model_manche(m_lfsr), 2'b01);
        @(negedge clk);
`endif
        do_reset();
        n_vec++;
        if (mismatch !== 1'b0) begin
            n_err++;
            $display("FAIL check_clear: mismatch=%b expected 0", mismatch);
        end
    endtask

    initial begin
        test_reset();
        test_init();
        test_match();
        test_void_rounds();
        test_timeout();
        test_reset_mid_match();
        test_checker();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
